imem_boot_ctrl: RTL and testbench

Boot/load controller for the 19-bit single-cycle CPU's 64-entry instruction memory. It receives a byte stream over a valid/ready handshake and assembles 19-bit instruction words. It writes them sequentially into the instruction RAM while holding the CPU stalled, then hands the RAM read port to the CPU fetch path. The block sits between the external loader link, the writable instruction RAM and the CPU's PC/instruction interface.

---
 rtl/imem_boot_ctrl.sv | 105 ++++++++++
 tb/tb_imem_boot_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot loader for the 64-entry instruction RAM: assembles 19-bit words from a byte stream,
// writes them sequentially while stalling the CPU, then hands the read port to instruction fetch.
module imem_boot_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          boot_req,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_instr,
    output logic          cpu_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          load_done,
    output logic [AW:0]   words_loaded
);

    typedef enum logic [2:0] {LEN, B0, B1, B2, WR, RUN} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state;
    logic [AW:0]   len_n;
    logic [AW-1:0] waddr;
    logic [DW-1:0] word_q;
    logic          hs;
    logic [6:0]    len_byte;
    logic [AW:0]   len_sel;
    logic [AW:0]   words_next;

    assign hs         = rx_valid && rx_ready;
    assign len_byte   = rx_data[6:0];
    assign words_next = words_loaded + (AW+1)'(1);

    // A zero or oversized length byte means "fill the whole RAM".
    assign len_sel = (len_byte == 7'd0 || 32'(len_byte) >= DEPTH) ? DEPTH_W : (AW+1)'(len_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LEN;
            len_n        <= '0;
            waddr        <= '0;
            word_q       <= '0;
            words_loaded <= '0;
            load_done    <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (boot_req) begin
                state <= LEN;
            end else begin
                case (state)
                    LEN: if (hs) begin
                        len_n        <= len_sel;
                        waddr        <= '0;
                        words_loaded <= '0;
                        word_q       <= '0;
                        state        <= B0;
                    end
                    B0: if (hs) begin
                        word_q[7:0] <= rx_data;
                        state       <= B1;
                    end
                    B1: if (hs) begin
                        word_q[15:8] <= rx_data;
                        state        <= B2;
                    end
                    B2: if (hs) begin
                        word_q[DW-1:16] <= rx_data[DW-17:0];
                        state           <= WR;
                    end
                    WR: begin
                        waddr        <= waddr + AW'(1);
                        words_loaded <= words_next;
                        if (words_next == len_n) begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end else begin
                            state <= B0;
                        end
                    end
                    RUN: state <= RUN;
                    default: state <= LEN;
                endcase
            end
        end
    end

    // Output decode: RUN gives the CPU the RAM, every other state keeps it stalled on a NOP.
    always_comb begin
        rx_ready  = (state == LEN) || (state == B0) || (state == B1) || (state == B2);
        mem_we    = (state == WR);
        mem_addr  = (state == RUN) ? cpu_addr : waddr;
        mem_wdata = (state == WR) ? word_q : '0;
        cpu_instr = (state == RUN) ? mem_rdata : '0;
        cpu_stall = (state != RUN);
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed testbench for imem_boot_ctrl with a behavioural RAM and write monitors.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_req;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [5:0]  cpu_addr;
    logic [18:0] cpu_instr;
    logic        cpu_stall;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [18:0] mem_wdata;
    logic [18:0] mem_rdata;
    logic        load_done;
    logic [6:0]  words_loaded;

    logic [18:0] ram [64];
    int wr_count = 0;
    int seq_idx  = 0;
    int seq_err  = 0;
    int bp_err   = 0;
    logic seq_mon = 1'b0;
    logic bp_mon  = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int h0;
    int wc;

    always #5 clk = ~clk;

    imem_boot_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .boot_req     (boot_req),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .cpu_addr     (cpu_addr),
        .cpu_instr    (cpu_instr),
        .cpu_stall    (cpu_stall),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .load_done    (load_done),
        .words_loaded (words_loaded)
    );

    assign mem_rdata = ram[mem_addr];

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 19'h0;
    end

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
    end

    // Sequential-address monitor for the full 64-word load with junk in byte 2.
    always @(posedge clk) begin
        if (!seq_mon) begin
            seq_idx <= 0;
        end else if (mem_we) begin
            if (mem_addr != seq_idx[5:0] || mem_wdata[18:16] != 3'b101) seq_err <= seq_err + 1;
            seq_idx <= seq_idx + 1;
        end
    end

    always @(negedge clk) begin
        if (bp_mon && !rx_ready && !mem_we) bp_err <= bp_err + 1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Presents one byte and waits (bounded) for the controller to take it.
    task automatic applyStimulus(input logic [7:0] b);
        bit done = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 16 && !done; t++) begin
            if (rx_ready) done = 1'b1;
            tick();
        end
        if (!done) checkOutput("hs_timeout", 32'd0, 32'd1);
    endtask

    task automatic sendSpaced(input logic [7:0] b);
        rx_valid = 1'b0;
        repeat (3) tick();
        applyStimulus(b);
        rx_valid = 1'b0;
    endtask

    task automatic pulseBoot();
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        boot_req = $urandom_range(0, 1);
        rx_valid = $urandom_range(0, 1);
        rx_data  = 8'($urandom);
        cpu_addr = 6'($urandom);
        repeat (3) tick();
        checkOutput("rst_rx_ready", rx_ready, 1);
        checkOutput("rst_cpu_stall", cpu_stall, 1);
        checkOutput("rst_cpu_instr", cpu_instr, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_load_done", load_done, 0);
        checkOutput("rst_words", words_loaded, 0);

        boot_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cpu_addr = 6'd0;
        rst_n    = 1'b1;
        repeat (5) tick();
        checkOutput("idle_rx_ready", rx_ready, 1);
        checkOutput("idle_cpu_stall", cpu_stall, 1);
        checkOutput("idle_mem_we", mem_we, 0);

        // Two-word load with rx_valid held high throughout.
        applyStimulus(8'h02);
        h0 = cyc;
        applyStimulus(8'h42);
        applyStimulus(8'h38);
        applyStimulus(8'h00);
        checkOutput("w0_we", mem_we, 1);
        checkOutput("w0_addr", mem_addr, 0);
        checkOutput("w0_wdata", mem_wdata, 19'h03842);
        checkOutput("w0_rx_ready", rx_ready, 0);
        applyStimulus(8'h42);
        applyStimulus(8'h36);
        applyStimulus(8'h00);
        checkOutput("w1_addr", mem_addr, 1);
        checkOutput("w1_wdata", mem_wdata, 19'h03642);
        tick();
        rx_valid = 1'b0;
        checkOutput("two_load_done", load_done, 1);
        checkOutput("two_done_cycle", cyc - h0 + 1, 9);
        checkOutput("two_stall", cpu_stall, 0);
        checkOutput("two_words", words_loaded, 2);
        checkOutput("two_rx_ready", rx_ready, 0);
        cpu_addr = 6'd1;
        #1;
        checkOutput("two_instr1", cpu_instr, 19'h03642);
        checkOutput("two_ram0", ram[0], 19'h03842);
        tick();
        checkOutput("two_done_pulse", load_done, 0);
        checkOutput("two_run_we", mem_we, 0);

        pulseBoot();
        checkOutput("boot_stall", cpu_stall, 1);
        checkOutput("boot_rx_ready", rx_ready, 1);
        checkOutput("boot_instr", cpu_instr, 0);

        // Length byte 0 means 64 words; byte 2 carries junk in its upper bits.
        seq_mon = 1'b1;
        applyStimulus(8'h00);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(8'(i));
            applyStimulus(8'h5A);
            applyStimulus(8'hFD);
        end
        checkOutput("full_last_addr", mem_addr, 63);
        checkOutput("full_last_wdata", mem_wdata, 19'h55A3F);
        tick();
        rx_valid = 1'b0;
        checkOutput("full_load_done", load_done, 1);
        checkOutput("full_stall", cpu_stall, 0);
        checkOutput("full_words", words_loaded, 64);
        repeat (5) tick();
        checkOutput("full_write_count", seq_idx, 64);
        checkOutput("full_seq_err", seq_err, 0);
        seq_mon = 1'b0;
        checkOutput("full_ram0", ram[0], 19'h55A00);
        cpu_addr = 6'd63;
        #1;
        checkOutput("full_instr63", cpu_instr, 19'h55A3F);

        // Three-word load with idle gaps between every byte.
        pulseBoot();
        bp_mon = 1'b1;
        sendSpaced(8'h03);
        sendSpaced(8'hAB); sendSpaced(8'hCD); sendSpaced(8'h06);
        sendSpaced(8'h01); sendSpaced(8'h80); sendSpaced(8'h02);
        sendSpaced(8'hFF); sendSpaced(8'hFF); sendSpaced(8'hFF);
        bp_mon = 1'b0;
        checkOutput("bp_last_we", mem_we, 1);
        tick();
        checkOutput("bp_load_done", load_done, 1);
        checkOutput("bp_words", words_loaded, 3);
        checkOutput("bp_ready_err", bp_err, 0);
        checkOutput("bp_ram0", ram[0], 19'h6CDAB);
        checkOutput("bp_ram1", ram[1], 19'h28001);
        checkOutput("bp_ram2", ram[2], 19'h7FFFF);
        checkOutput("bp_ram3_kept", ram[3], 19'h55A03);

        // boot_req collides with a byte handshake in the middle of word 1.
        pulseBoot();
        applyStimulus(8'h05);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        applyStimulus(8'h04);
        applyStimulus(8'h05);
        wc = wr_count;
        boot_req = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h06;
        #1;
        checkOutput("abort_rx_ready", rx_ready, 1);
        tick();
        boot_req = 1'b0;
        rx_valid = 1'b0;
        checkOutput("abort_stall", cpu_stall, 1);
        checkOutput("abort_we", mem_we, 0);
        checkOutput("abort_words", words_loaded, 1);
        repeat (3) tick();
        checkOutput("abort_no_write", wr_count, wc);
        checkOutput("abort_ram0", ram[0], 19'h30201);
        applyStimulus(8'h01);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h03);
        rx_valid = 1'b0;
        checkOutput("reload_addr", mem_addr, 0);
        checkOutput("reload_wdata", mem_wdata, 19'h32211);
        tick();
        checkOutput("reload_done", load_done, 1);
        checkOutput("reload_words", words_loaded, 1);
        checkOutput("reload_ram0", ram[0], 19'h32211);
        checkOutput("reload_ram1_kept", ram[1], 19'h28001);

        // Asynchronous reset landing in the middle of a WR cycle.
        pulseBoot();
        applyStimulus(8'h02);
        applyStimulus(8'h44);
        applyStimulus(8'h33);
        applyStimulus(8'h01);
        rx_valid = 1'b0;
        checkOutput("wr_before_rst", mem_we, 1);
        wc = wr_count;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_we", mem_we, 0);
        checkOutput("arst_stall", cpu_stall, 1);
        checkOutput("arst_rx_ready", rx_ready, 1);
        checkOutput("arst_words", words_loaded, 0);
        checkOutput("arst_wdata", mem_wdata, 0);
        tick();
        checkOutput("arst_no_write", wr_count, wc);
        checkOutput("arst_ram0", ram[0], 19'h32211);
        rst_n = 1'b1;
        repeat (2) tick();
        checkOutput("post_rst_ready", rx_ready, 1);
        checkOutput("post_rst_stall", cpu_stall, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
